mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_arb_rr2.sv | 26 ++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache memory arbiter: widths, FSM encoding,
// requester sides and memory opcode values.
package mem_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int LINE_SIZE = 64;

    // Value of d_we selecting each memory operation
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_t;

    function automatic side_t other_side(input side_t s);
        return (s == SIDE_I) ? SIDE_D : SIDE_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a conflict goes to the side that did not win last time.
module arb_rr2
    import mem_arbiter_pkg::side_t;
    import mem_arbiter_pkg::SIDE_I;
    import mem_arbiter_pkg::SIDE_D;
    import mem_arbiter_pkg::other_side;
(
    input  logic  req_i,
    input  logic  req_d,
    input  side_t last_grant,
    output logic  grant_valid,
    output side_t grant
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant       = SIDE_I;
        if (req_i && req_d) begin
            grant = other_side(last_grant);
        end else if (req_d) begin
            grant = SIDE_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache line requests onto one memory port,
// with registered outputs, round-robin conflict handling and an ack timeout.
module mem_arbiter
    import mem_arbiter_pkg::state_t;
    import mem_arbiter_pkg::ST_IDLE;
    import mem_arbiter_pkg::ST_I_BUSY;
    import mem_arbiter_pkg::ST_D_BUSY;
    import mem_arbiter_pkg::ST_RESP;
    import mem_arbiter_pkg::side_t;
    import mem_arbiter_pkg::SIDE_I;
    import mem_arbiter_pkg::SIDE_D;
    import mem_arbiter_pkg::OP_READ;
    import mem_arbiter_pkg::OP_WRITE;
#(
    parameter int WORD_SIZE = mem_arbiter_pkg::WORD_SIZE,
    parameter int LINE_SIZE = mem_arbiter_pkg::LINE_SIZE,
    parameter int TIMEOUT   = 255
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_done,
    output logic [LINE_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [LINE_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [LINE_SIZE-1:0] d_rdata,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [LINE_SIZE-1:0] m_wdata,
    input  logic [LINE_SIZE-1:0] m_rdata,
    input  logic                 m_ack,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_reg, state_next;
    side_t                 last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [WORD_SIZE-1:0]  addr_reg, addr_next;
    logic [LINE_SIZE-1:0]  wdata_reg, wdata_next;
    logic                  read_reg, read_next;
    logic                  write_reg, write_next;
    logic                  i_done_reg, i_done_next;
    logic                  d_done_reg, d_done_next;
    logic [LINE_SIZE-1:0]  i_rdata_reg, i_rdata_next;
    logic [LINE_SIZE-1:0]  d_rdata_reg, d_rdata_next;
    logic                  busy_reg, busy_next;
    logic                  err_reg, err_next;

    logic                  grant_valid;
    side_t                 grant;

    arb_rr2 u_arb (
        .req_i       (i_req),
        .req_d       (d_req),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] a);
        return {a[WORD_SIZE-1:2], 2'b00};
    endfunction

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        read_next       = read_reg;
        write_next      = write_reg;
        i_done_next     = 1'b0;
        d_done_next     = 1'b0;
        i_rdata_next    = i_rdata_reg;
        d_rdata_next    = d_rdata_reg;
        busy_next       = busy_reg;
        err_next        = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    cnt_next  = '0;
                    busy_next = 1'b1;
                    if (grant == SIDE_I) begin
                        state_next = ST_I_BUSY;
                        addr_next  = line_align(i_addr);
                        read_next  = 1'b1;
                        write_next = 1'b0;
                    end else begin
                        state_next = ST_D_BUSY;
                        addr_next  = line_align(d_addr);
                        wdata_next = d_wdata;
                        read_next  = (d_we == OP_READ);
                        write_next = (d_we == OP_WRITE);
                    end
                end
            end

            ST_I_BUSY, ST_D_BUSY: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // A real ack wins over a timeout expiring in the same cycle
                if (m_ack || cnt_reg == CNT_LAST) begin
                    state_next      = ST_RESP;
                    read_next       = 1'b0;
                    write_next      = 1'b0;
                    err_next        = err_reg | ~m_ack;
                    last_grant_next = (state_reg == ST_I_BUSY) ? SIDE_I : SIDE_D;
                    if (state_reg == ST_I_BUSY) begin
                        i_done_next = 1'b1;
                        if (m_ack) i_rdata_next = m_rdata;
                    end else begin
                        d_done_next = 1'b1;
                        if (m_ack && read_reg) d_rdata_next = m_rdata;
                    end
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end

            default: begin
                state_next = ST_IDLE;
                read_next  = 1'b0;
                write_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= SIDE_I;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            i_done_reg     <= 1'b0;
            d_done_reg     <= 1'b0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            i_done_reg     <= i_done_next;
            d_done_reg     <= d_done_next;
            i_rdata_reg    <= i_rdata_next;
            d_rdata_reg    <= d_rdata_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    assign i_done      = i_done_reg;
    assign d_done      = d_done_reg;
    assign i_rdata     = i_rdata_reg;
    assign d_rdata     = d_rdata_reg;
    assign m_readM     = read_reg;
    assign m_writeM    = write_reg;
    assign m_address   = addr_reg;
    assign m_wdata     = wdata_reg;
    assign busy        = busy_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WS = 16;
    localparam int LS = 64;
    localparam int TO = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          i_req, d_req, d_we, m_ack;
    logic [WS-1:0] i_addr, d_addr;
    logic [LS-1:0] d_wdata, m_rdata;
    logic          i_done, d_done, m_readM, m_writeM, busy, err_timeout;
    logic [LS-1:0] i_rdata, d_rdata, m_wdata;
    logic [WS-1:0] m_address;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            last_d;
    logic [LS-1:0] exp_i_rdata, exp_d_rdata, exp_mwdata;
    logic          exp_err;

    mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_readM"}, m_readM, 1'b0);
        chk1({tag, "_writeM"}, m_writeM, 1'b0);
        chk1({tag, "_i_done"}, i_done, 1'b0);
        chk1({tag, "_d_done"}, d_done, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_err"}, err_timeout, 1'b0);
        chkw({tag, "_i_rdata"}, i_rdata, '0);
        chkw({tag, "_d_rdata"}, d_rdata, '0);
        chkw({tag, "_m_wdata"}, m_wdata, '0);
        chka({tag, "_m_address"}, m_address, '0);
    endtask

    task automatic model_reset();
        last_d      = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_mwdata  = '0;
        exp_err     = 1'b0;
    endtask

    // One full transaction starting from IDLE with requests already driven.
    // delay = BUSY cycle carrying m_ack (1-based); 0 = memory never answers.
    task automatic do_txn(input int delay, input logic [LS-1:0] rd);
        bit            own_d, is_wr, timed;
        int            nb;
        logic [WS-1:0] a;
        if (i_req && d_req) own_d = !last_d;
        else                own_d = d_req;
        a      = own_d ? d_addr : i_addr;
        a[1:0] = 2'b00;
        is_wr  = own_d && d_we;
        if (own_d) exp_mwdata = d_wdata;
        timed = (delay == 0);
        nb    = timed ? TO : delay;
        step();
        for (int c = 1; c <= nb; c++) begin
            chk1("busy_in_txn", busy, 1'b1);
            chka("m_address", m_address, a);
            chk1("m_readM", m_readM, !is_wr);
            chk1("m_writeM", m_writeM, is_wr);
            chkw("m_wdata", m_wdata, exp_mwdata);
            chk1("err_during", err_timeout, exp_err);
            chk1("no_early_i_done", i_done, 1'b0);
            chk1("no_early_d_done", d_done, 1'b0);
            // Requester inputs wander after grant; latched values must not move
            i_addr  = WS'($urandom);
            d_addr  = WS'($urandom);
            d_we    = 1'($urandom);
            d_wdata = {$urandom, $urandom};
            m_rdata = {$urandom, $urandom};
            if (c == nb && !timed) begin
                m_ack   = 1'b1;
                m_rdata = rd;
            end
            step();
            m_ack = 1'b0;
        end
        if (timed) exp_err = 1'b1;
        else if (!is_wr) begin
            if (own_d) exp_d_rdata = rd;
            else       exp_i_rdata = rd;
        end
        last_d = own_d;
        chk1("resp_i_done", i_done, !own_d);
        chk1("resp_d_done", d_done, own_d);
        chk1("resp_readM", m_readM, 1'b0);
        chk1("resp_writeM", m_writeM, 1'b0);
        chk1("resp_busy", busy, 1'b1);
        chkw("i_rdata", i_rdata, exp_i_rdata);
        chkw("d_rdata", d_rdata, exp_d_rdata);
        chk1("err_timeout", err_timeout, exp_err);
        $display("txn side=%s addr=%h write=%0d busy_cycles=%0d timeout=%0d",
                 own_d ? "D" : "I", a, is_wr, nb, timed);
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
        step();
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_i_done", i_done, 1'b0);
        chk1("idle_d_done", d_done, 1'b0);
    endtask

    initial begin
        logic [1:0] r;
        Reset   = 1'b1;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        m_ack   = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        model_reset();
        step();
        step();
        chk_reset_vals("reset");
        Reset = 1'b0;
        step();
        chk1("idle_no_req", busy, 1'b0);

        // Lone instruction read, unaligned address, ack on third BUSY cycle
        i_req  = 1'b1;
        i_addr = 16'h0013;
        do_txn(3, 64'h1111_2222_3333_4444);

        // Simultaneous requests: D first after reset, then I, twice
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = WS'($urandom); d_addr = WS'($urandom);
        do_txn(2, {$urandom, $urandom});
        do_txn(1, {$urandom, $urandom});
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        do_txn(4, {$urandom, $urandom});
        do_txn(2, {$urandom, $urandom});

        // Data write-back leaves d_rdata alone
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0122;
        d_wdata = 64'hDEAD_BEEF_0000_FFFF;
        do_txn(2, {$urandom, $urandom});

        // Stray ack while idle is ignored
        m_ack   = 1'b1;
        m_rdata = {$urandom, $urandom};
        step();
        m_ack = 1'b0;
        chk1("stray_ack_busy", busy, 1'b0);
        chk1("stray_ack_i_done", i_done, 1'b0);
        chk1("stray_ack_d_done", d_done, 1'b0);
        chkw("stray_ack_i_rdata", i_rdata, exp_i_rdata);
        chkw("stray_ack_d_rdata", d_rdata, exp_d_rdata);

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            if (!i_req && !d_req) begin
                r = 2'($urandom_range(1, 3));
                if (r[0]) begin i_req = 1'b1; i_addr = WS'($urandom); end
                if (r[1]) begin
                    d_req = 1'b1; d_addr = WS'($urandom);
                    d_we = 1'($urandom); d_wdata = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 1) == 1) begin
                if (!i_req) begin i_req = 1'b1; i_addr = WS'($urandom); end
                else if (!d_req) begin
                    d_req = 1'b1; d_addr = WS'($urandom);
                    d_we = 1'($urandom); d_wdata = {$urandom, $urandom};
                end
            end
            do_txn(int'($urandom_range(1, 7)), {$urandom, $urandom});
        end
        for (int n = 0; n < 2; n++) begin
            if (i_req || d_req) do_txn(1, {$urandom, $urandom});
        end

        // Memory never answers: timeout after TO BUSY cycles, flag sticks
        i_req = 1'b1;
        do_txn(0, {$urandom, $urandom});
        step();
        chk1("err_sticky", err_timeout, 1'b1);

        // Reset in the middle of a data transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = WS'($urandom);
        step();
        chk1("pre_reset_busy", busy, 1'b1);
        chk1("pre_reset_readM", m_readM, 1'b1);
        step();
        Reset = 1'b1;
        step();
        model_reset();
        chk_reset_vals("mid_reset");
        Reset = 1'b0;
        d_req = 1'b0;
        step();
        chk1("post_reset_d_done", d_done, 1'b0);
        chk1("post_reset_busy", busy, 1'b0);
        chk1("post_reset_readM", m_readM, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
